// File: rtl/dmem_bus_if.sv
// Core-side data bus plus the TX FIFO output handshake.
// The core or testbench is the master and dmem_bus is the slave.
interface dmem_bus_if;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output MemWrite,
    output addr,
    output writedata,
    output out_ready,
    input  readdata,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  MemWrite,
    input  addr,
    input  writedata,
    input  out_ready,
    output readdata,
    output out_data,
    output out_valid
  );
endinterface

// File: rtl/dmem_bus.sv
// Data-memory bus for a single-cycle core: word RAM, a cycle
// counter and an 8-deep TX FIFO, with a zero-latency read path.
module dmem_bus #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  dmem_bus_if.slave bus
);
  localparam logic [3:0] FullCnt = 4'(FIFO_DEPTH);

  logic [31:0] ram_q  [256];
  logic [31:0] fifo_q [8];

  logic [31:0] cyc_q, cyc_d;
  logic [2:0]  wp_q, wp_d;
  logic [2:0]  rp_q, rp_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;

  logic        hi_zero;
  logic        sel_ram, sel_cyc;
  logic        sel_tx, sel_st;
  logic        empty, full;
  logic        pop, push_req, push;
  logic [31:0] status;
  logic        unused_lo;

  assign unused_lo = ^bus.addr[1:0];

  always_comb begin
    hi_zero = (bus.addr[31:13] == '0);
    sel_ram = hi_zero && (bus.addr[12:10] == 3'b000);
    sel_cyc = hi_zero && (bus.addr[12:2] == 11'h400);
    sel_tx  = hi_zero && (bus.addr[12:2] == 11'h401);
    sel_st  = hi_zero && (bus.addr[12:2] == 11'h402);
  end

  assign empty  = (cnt_q == 4'd0);
  assign full   = (cnt_q == FullCnt);
  assign status = {25'd0, ovf_q, cnt_q, full, empty};

  always_comb begin
    bus.readdata = '0;
    unique case (1'b1)
      sel_ram: bus.readdata = ram_q[bus.addr[9:2]];
      sel_cyc: bus.readdata = cyc_q;
      sel_st:  bus.readdata = status;
      default: bus.readdata = '0;
    endcase
  end

  // A pop on the same edge frees the slot a full-FIFO push needs.
  always_comb begin
    pop      = !empty && bus.out_ready;
    push_req = bus.MemWrite && sel_tx;
    push     = push_req && (!full || pop);

    cyc_d = cyc_q + 32'd1;
    if (bus.MemWrite && sel_cyc) begin
      cyc_d = bus.writedata;
    end

    ovf_d = ovf_q;
    if (push_req && !push) begin
      ovf_d = 1'b1;
    end else if (bus.MemWrite && sel_st &&
                 bus.writedata[6]) begin
      ovf_d = 1'b0;
    end

    wp_d  = wp_q + {2'b00, push};
    rp_d  = rp_q + {2'b00, pop};
    cnt_d = cnt_q + {3'b000, push}
                  - {3'b000, pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cyc_q <= cyc_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Storage arrays carry no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (bus.MemWrite && sel_ram) begin
      ram_q[bus.addr[9:2]] <= bus.writedata;
    end
    if (push) begin
      fifo_q[wp_q] <= bus.writedata;
    end
  end

  assign bus.out_data  = fifo_q[rp_q];
  assign bus.out_valid = !empty;
endmodule

// File: tb/tb_dmem_bus.sv
// Directed bench for dmem_bus: vector table for the address map,
// hand sequences for FIFO fill/drain and async reset.
module tb_dmem_bus;
  logic clk;
  logic reset;

  dmem_bus_if bus ();

  dmem_bus #(.FIFO_DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run;
  int n_fail;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic        c;
    logic [31:0] e;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic we, input logic [31:0] a,
                     input logic [31:0] wd, input logic c,
                     input logic [31:0] e);
    vec_t v;
    v.we = we;
    v.a  = a;
    v.wd = wd;
    v.c  = c;
    v.e  = e;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set(input logic we, input logic [31:0] a,
                     input logic [31:0] wd, input logic rdy);
    bus.MemWrite  = we;
    bus.addr      = a;
    bus.writedata = wd;
    bus.out_ready = rdy;
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_run  = 0;
    n_fail = 0;
    reset  = 1'b1;
    set(1'b0, 32'h0000_1008, 32'h0, 1'b0);

    add(0, 32'h1000, 0, 1, 32'd0);
    add(0, 32'h1000, 0, 1, 32'd1);
    add(0, 32'h1000, 0, 1, 32'd2);
    add(0, 32'h1000, 0, 1, 32'd3);
    add(0, 32'h1000, 0, 1, 32'd4);
    add(0, 32'h1000, 0, 1, 32'd5);
    add(1, 32'h014, 32'h2222_2222, 0, 0);
    add(1, 32'h010, 32'h1111_1111, 0, 0);
    add(1, 32'h010, 32'hDEAD_BEEF, 1, 32'h1111_1111);
    add(0, 32'h010, 0, 1, 32'hDEAD_BEEF);
    add(0, 32'h011, 0, 1, 32'hDEAD_BEEF);
    add(0, 32'h013, 0, 1, 32'hDEAD_BEEF);
    add(0, 32'h014, 0, 1, 32'h2222_2222);
    add(1, 32'h3FC, 32'hCAFE_F00D, 0, 0);
    add(0, 32'h3FC, 0, 1, 32'hCAFE_F00D);
    add(0, 32'h400, 0, 1, 32'h0);
    add(1, 32'h410, 32'h5555_5555, 1, 32'h0);
    add(0, 32'h010, 0, 1, 32'hDEAD_BEEF);
    add(0, 32'h1004, 0, 1, 32'h0);
    add(0, 32'h100C, 0, 1, 32'h0);
    add(0, 32'h8000_1000, 0, 1, 32'h0);
    add(0, 32'h3000, 0, 1, 32'h0);
    add(1, 32'h2000, 32'h1234_5678, 1, 32'h0);
    add(0, 32'h2000, 0, 1, 32'h0);
    add(0, 32'h010, 0, 1, 32'hDEAD_BEEF);
    add(0, 32'h1008, 0, 1, 32'h01);
    add(0, 32'h1000, 0, 1, 32'd26);
    add(1, 32'h1000, 32'hFFFF_FFFE, 1, 32'd27);
    add(0, 32'h1000, 0, 1, 32'hFFFF_FFFE);
    add(0, 32'h1000, 0, 1, 32'hFFFF_FFFF);
    add(0, 32'h1000, 0, 1, 32'h0);
    add(0, 32'h1000, 0, 1, 32'h1);
    add(1, 32'h1008, 32'h40, 1, 32'h01);

    half();
    chk("rst_status", bus.readdata, 32'h01);
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    set(1'b0, 32'h1000, 32'h0, 1'b0);
    #1;
    chk("rst_cycle", bus.readdata, 32'h0);
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      set(vt[i].we, vt[i].a, vt[i].wd, 1'b0);
      half();
      if (vt[i].c) begin
        chk($sformatf("vec%0d", i), bus.readdata, vt[i].e);
      end
      tick();
    end

    for (int i = 1; i <= 8; i++) begin
      set(1'b1, 32'h1004, 32'(i), 1'b0);
      half();
      chk("txpush_rd", bus.readdata, 32'h0);
      tick();
    end
    set(1'b0, 32'h1008, 32'h0, 1'b0);
    half();
    chk("fill_status", bus.readdata, 32'h22);
    chk("fill_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("fill_head", bus.out_data, 32'd1);
    tick();
    set(1'b1, 32'h1004, 32'd9, 1'b0);
    tick();
    set(1'b0, 32'h1008, 32'h0, 1'b0);
    half();
    chk("ovf_status", bus.readdata, 32'h62);
    tick();
    for (int k = 1; k <= 8; k++) begin
      set(1'b0, 32'h1008, 32'h0, 1'b1);
      half();
      chk($sformatf("drain%0d", k), bus.out_data, 32'(k));
      tick();
    end
    half();
    chk("drained_status", bus.readdata, 32'h41);
    chk("drained_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    set(1'b1, 32'h1008, 32'hFFFF_FFBF, 1'b0);
    tick();
    set(1'b0, 32'h1008, 32'h0, 1'b0);
    half();
    chk("st_wr_nobit6", bus.readdata, 32'h41);
    tick();
    set(1'b1, 32'h1008, 32'h40, 1'b0);
    tick();
    set(1'b0, 32'h1008, 32'h0, 1'b0);
    half();
    chk("ovf_clear", bus.readdata, 32'h01);
    tick();

    for (int i = 0; i < 8; i++) begin
      set(1'b1, 32'h1004, 32'h10 + 32'(i), 1'b0);
      tick();
    end
    set(1'b1, 32'h1004, 32'hA5, 1'b1);
    half();
    chk("pp_head", bus.out_data, 32'h10);
    tick();
    set(1'b0, 32'h1008, 32'h0, 1'b0);
    half();
    chk("pp_status", bus.readdata, 32'h22);
    tick();
    for (int k = 1; k <= 8; k++) begin
      set(1'b0, 32'h1008, 32'h0, 1'b1);
      half();
      chk($sformatf("pp_drain%0d", k), bus.out_data,
          (k == 8) ? 32'hA5 : 32'h10 + 32'(k));
      tick();
    end
    set(1'b0, 32'h1008, 32'h0, 1'b0);
    half();
    chk("pp_empty", bus.readdata, 32'h01);
    tick();

    for (int i = 0; i < 6; i++) begin
      set(1'b1, 32'h1004, 32'h30 + 32'(i), 1'b0);
      tick();
    end
    set(1'b0, 32'h1008, 32'h0, 1'b1);
    tick();
    set(1'b0, 32'h1008, 32'h0, 1'b0);
    half();
    chk("mid_status", bus.readdata, 32'h14);
    chk("mid_head", bus.out_data, 32'h31);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_status", bus.readdata, 32'h01);
    tick();
    set(1'b1, 32'h1004, 32'h77, 1'b0);
    tick();
    set(1'b1, 32'h1000, 32'h1234, 1'b0);
    tick();
    set(1'b1, 32'h1004, 32'h78, 1'b0);
    tick();
    set(1'b0, 32'h1008, 32'h0, 1'b0);
    #1;
    chk("rst_push_ign", bus.readdata, 32'h01);
    set(1'b0, 32'h1000, 32'h0, 1'b0);
    #1;
    chk("rst_cyc_ign", bus.readdata, 32'h0);
    tick();
    reset = 1'b0;
    half();
    chk("rel_cyc0", bus.readdata, 32'h0);
    tick();
    half();
    chk("rel_cyc1", bus.readdata, 32'h1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
